// File: rtl/flappy_pkg.sv
// Shared game types and default bird physics constants, so the renderer and
// the controller agree on state encoding and fixed-point scaling.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DEAD    = 2'd2
  } bird_state_t;

  localparam int unsigned DEF_FRAC_BITS      = 4;
  localparam int unsigned DEF_GRAVITY        = 6;
  localparam int unsigned DEF_FLAP_VELOCITY  = 96;
  localparam int unsigned DEF_MAX_FALL_SPEED = 160;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous button followed by a one-cycle
// rising-edge pulse.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/bird_controller.sv
// Per-frame bird physics and game state machine, clocked by the pixel clock;
// also flags pixels covered by the bird sprite.
module bird_controller
  import flappy_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 1280,
  parameter int unsigned VER_ACTIVE_PIXELS = 720,
  parameter int unsigned BIRD_X            = 320,
  parameter int unsigned BIRD_SIZE         = 32,
  parameter int unsigned START_Y           = 344,
  parameter int unsigned FRAC_BITS         = DEF_FRAC_BITS,
  parameter int unsigned GRAVITY           = DEF_GRAVITY,
  parameter int unsigned FLAP_VELOCITY     = DEF_FLAP_VELOCITY,
  parameter int unsigned MAX_FALL_SPEED    = DEF_MAX_FALL_SPEED,
  localparam int unsigned X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int unsigned Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic               vs,
  input  logic               de,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               flap,
  output logic [Y_WIDTH-1:0] bird_y,
  output logic               bird_pixel,
  output logic [1:0]         state,
  output logic [15:0]        score
);

  localparam int unsigned PW = Y_WIDTH + FRAC_BITS;
  localparam int unsigned VW = PW + 1;
  localparam int unsigned NW = PW + 2;

  localparam logic [PW-1:0]        START_POS = PW'(START_Y << FRAC_BITS);
  localparam logic [PW-1:0]        FLOOR_POS = PW'((VER_ACTIVE_PIXELS - BIRD_SIZE) << FRAC_BITS);
  localparam logic signed [NW-1:0] FLOOR_S   = $signed({2'b00, FLOOR_POS});
  localparam logic signed [VW-1:0] GRAV_S    = VW'(GRAVITY);
  localparam logic signed [VW-1:0] FLAP_S    = VW'(FLAP_VELOCITY);
  localparam logic signed [VW-1:0] MAXF_S    = VW'(MAX_FALL_SPEED);
  localparam logic [X_WIDTH:0]     X_LO      = (X_WIDTH+1)'(BIRD_X);
  localparam logic [X_WIDTH:0]     X_HI      = (X_WIDTH+1)'(BIRD_X + BIRD_SIZE);
  localparam logic [Y_WIDTH:0]     Y_SIZE    = (Y_WIDTH+1)'(BIRD_SIZE);

  bird_state_t             state_q, state_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic signed [VW-1:0]    vel_q, vel_d;
  logic [15:0]             score_q, score_d;
  logic                    pending_q, pending_d;
  logic                    vs_q;
  logic                    pixel_q, pixel_d;

  logic                    flap_edge, frame_tick, flap_now, advance;
  logic signed [VW-1:0]    vel_sum, vel_n;
  logic signed [NW-1:0]    p_next;
  logic [15:0]             score_inc;
  logic [Y_WIDTH:0]        y_top, y_bot;
  logic [X_WIDTH:0]        x_ext;

  sync_edge_detect u_flap_sync (
    .clk_i   (clk_rgb),
    .rst_i   (rst),
    .d_i     (flap),
    .pulse_o (flap_edge)
  );

  always_comb begin
    frame_tick = vs & ~vs_q;
    // An edge landing on the tick cycle itself is folded in directly.
    flap_now   = pending_q | flap_edge;
    pending_d  = frame_tick ? 1'b0 : flap_now;

    vel_sum = vel_q + GRAV_S;
    if (flap_now)              vel_n = -FLAP_S;
    else if (vel_sum > MAXF_S) vel_n = MAXF_S;
    else                       vel_n = vel_sum;
    p_next    = $signed({2'b00, pos_q}) + NW'(vel_n);
    score_inc = (score_q == '1) ? score_q : score_q + 16'd1;

    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    score_d = score_q;
    advance = 1'b0;

    if (frame_tick) begin
      case (state_q)
        IDLE:    advance = flap_now;
        RUNNING: advance = 1'b1;
        DEAD: begin
          if (flap_now) begin
            state_d = IDLE;
            pos_d   = START_POS;
            vel_d   = '0;
            score_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      state_d = RUNNING;
      score_d = score_inc;
      if (p_next < 0) begin
        pos_d = '0;
        vel_d = '0;
      end else if (p_next >= FLOOR_S) begin
        pos_d   = FLOOR_POS;
        vel_d   = '0;
        state_d = DEAD;
      end else begin
        pos_d = p_next[PW-1:0];
        vel_d = vel_n;
      end
    end

    x_ext   = {1'b0, x};
    y_top   = {1'b0, bird_y};
    y_bot   = y_top + Y_SIZE;
    pixel_d = de && (x_ext >= X_LO) && (x_ext < X_HI)
                 && ({1'b0, y} >= y_top) && ({1'b0, y} < y_bot);
  end

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= START_POS;
      vel_q     <= '0;
      score_q   <= '0;
      pending_q <= 1'b0;
      vs_q      <= 1'b0;
      pixel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      score_q   <= score_d;
      pending_q <= pending_d;
      vs_q      <= vs;
      pixel_q   <= pixel_d;
    end
  end

  assign bird_y     = pos_q[PW-1:FRAC_BITS];
  assign state      = state_q;
  assign score      = score_q;
  assign bird_pixel = pixel_q;

endmodule

// File: tb/tb_bird_controller.sv
// Directed and randomized frame sequences for bird_controller, checked against
// a frame-level reference model of the game rules.
module tb_bird_controller;

  localparam int START = 344;
  localparam int G     = 6;
  localparam int FV    = 96;
  localparam int MAXF  = 160;
  localparam int FLOOR = (720 - 32) * 16;
  localparam int BX    = 320;
  localparam int BS    = 32;

  logic        clk_rgb = 1'b0;
  logic        rst = 1'b0, vs = 1'b0, de = 1'b0, flap = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic [9:0]  bird_y;
  logic        bird_pixel;
  logic [1:0]  state;
  logic [15:0] score;

  int total = 0;
  int bad   = 0;
  int mpos, mvel, mstate, mscore;

  always #5 clk_rgb = ~clk_rgb;

  bird_controller dut (
    .clk_rgb    (clk_rgb),
    .rst        (rst),
    .vs         (vs),
    .de         (de),
    .x          (x),
    .y          (y),
    .flap       (flap),
    .bird_y     (bird_y),
    .bird_pixel (bird_pixel),
    .state      (state),
    .score      (score)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_rgb);
  endtask

  task automatic model_reset();
    mpos = START * 16; mvel = 0; mstate = 0; mscore = 0;
  endtask

  // One frame of game rules: 0=IDLE, 1=RUNNING, 2=DEAD; positions in 1/16 px.
  task automatic model_tick(input bit f);
    int vn, p;
    if (mstate == 2) begin
      if (f) model_reset();
    end else if (mstate == 1 || f) begin
      vn = f ? -FV : ((mvel + G > MAXF) ? MAXF : mvel + G);
      p  = mpos + vn;
      mstate = 1;
      mscore = (mscore == 65535) ? 65535 : mscore + 1;
      if (p < 0) begin mpos = 0; mvel = 0; end
      else if (p >= FLOOR) begin mpos = FLOOR; mvel = 0; mstate = 2; end
      else begin mpos = p; mvel = vn; end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_bird_y"}, bird_y, mpos / 16);
    check({tag, "_state"},  state,  mstate);
    check({tag, "_score"},  score,  mscore);
  endtask

  // co=1 times the synchronized flap edge onto the very cycle of the vs rise.
  task automatic run_frame(input bit f, input bit co, input int gap, input string tag);
    repeat (gap) step();
    if (f && !co) begin
      flap = 1'b1; repeat (3) step();
      flap = 1'b0; repeat (2) step();
    end
    if (f && co) begin
      flap = 1'b1; step(); step();
    end
    vs = 1'b1; step();
    model_tick(f);
    check_model(tag);
    flap = 1'b0; step(); step();
    vs = 1'b0; step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
  endtask

  task automatic pixel_probe(input bit d, input int px, input int py, input string tag);
    int by;
    bit e;
    by = mpos / 16;
    de = d; x = 11'(px); y = 10'(py);
    step();
    e = d && px >= BX && px < BX + BS && py >= by && py < by + BS;
    check(tag, bird_pixel, e);
  endtask

  initial begin
    step();
    // Reset with a pixel that would hit the sprite.
    de = 1'b1; x = 11'd320; y = 10'd344;
    do_reset();
    check_model("reset");
    check("reset_pixel", bird_pixel, 0);
    de = 1'b0;
    step();

    for (int i = 0; i < 10; i++) run_frame(1'b0, 1'b0, 2, "idle");
    check("idle_y", bird_y, 344);

    run_frame(1'b1, 1'b0, 2, "first_flap");
    check("first_flap_y", bird_y, 338);
    check("first_flap_state", state, 1);
    run_frame(1'b0, 1'b0, 2, "second");
    check("second_y", bird_y, 332);
    check("second_score", score, 2);

    for (int i = 0; i < 300 && mstate != 2; i++) run_frame(1'b0, 1'b0, 1, "fall");
    check("floor_y", bird_y, 688);
    check("floor_state", state, 2);
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1, "dead_hold");
    run_frame(1'b1, 1'b0, 1, "restart");
    check("restart_state", state, 0);

    run_frame(1'b1, 1'b0, 1, "co_start");
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1, "co_pre");
    run_frame(1'b1, 1'b1, 1, "coincide");
    run_frame(1'b0, 1'b0, 1, "co_post");

    for (int i = 0; i < 150 && !(mpos == 0 && mstate == 1); i++)
      run_frame(1'b1, 1'b0, 1, "ceil");
    check("ceil_y", bird_y, 0);
    check("ceil_state", state, 1);
    run_frame(1'b1, 1'b0, 1, "ceil_again");
    run_frame(1'b0, 1'b0, 1, "ceil_drop1");
    run_frame(1'b0, 1'b0, 1, "ceil_drop2");

    for (int i = 0; i < 200; i++) begin
      bit f, co;
      f  = ($urandom_range(2) == 0);
      co = f && ($urandom_range(3) == 0);
      run_frame(f, co, $urandom_range(4), "rand");
    end

    for (int i = 0; i < 40; i++) begin
      int by;
      by = mpos / 16;
      pixel_probe($urandom_range(3) != 0, $urandom_range(370, 300),
                  (by < 40 ? 0 : by - 40) + $urandom_range(90), "rand_pixel");
    end
    de = 1'b0;

    do_reset();
    check_model("sprite_reset");
    pixel_probe(1'b1, 320, 344, "pix_hit");
    pixel_probe(1'b1, 352, 344, "pix_right");
    pixel_probe(1'b1, 320, 376, "pix_below");
    pixel_probe(1'b0, 320, 344, "pix_de0");
    pixel_probe(1'b1, 351, 375, "pix_corner");
    pixel_probe(1'b1, 319, 350, "pix_left");
    pixel_probe(1'b1, 330, 343, "pix_above");
    de = 1'b0;

    run_frame(1'b1, 1'b0, 1, "mid_start");
    run_frame(1'b0, 1'b0, 1, "mid_run");
    run_frame(1'b0, 1'b0, 1, "mid_run");
    do_reset();
    check_model("mid_reset");
    check("mid_reset_y", bird_y, 344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bird_controller.md
Name: bird_controller

Overview:
- Game-logic stage for the bird: consumes the pixel iterator's timing outputs (vs, de, x, y) plus the raw flap button, and runs per-frame bird physics and a game state machine.
- Produces the bird's vertical position, a per-pixel "bird covers this pixel" flag for the RGB select logic, the game state and a survival score.
- Runs in the pixel clock domain, so frame updates happen once per vertical sync.

Parameters:
- HOR_ACTIVE_PIXELS, 1280, active width; X_WIDTH = $clog2 of it.
- VER_ACTIVE_PIXELS, 720, active height; Y_WIDTH = $clog2 of it.
- BIRD_X, 320, fixed left column of the bird sprite.
- BIRD_SIZE, 32, square sprite side in pixels.
- START_Y, 344, bird top row in IDLE.
- FRAC_BITS, 4, fractional bits of position and velocity.
- GRAVITY, 6, velocity increment per frame (1/16 px/frame units).
- FLAP_VELOCITY, 96, magnitude of upward velocity set by a flap.
- MAX_FALL_SPEED, 160, downward velocity cap.

Ports:
- clk_rgb  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- vs  input  1  vertical sync from pixel iterator
- de  input  1  data enable from pixel iterator
- x  input  X_WIDTH  current pixel column
- y  input  Y_WIDTH  current pixel row
- flap  input  1  raw, asynchronous flap button (active-high)
- bird_y  output  Y_WIDTH  integer top row of bird (pos >> FRAC_BITS)
- bird_pixel  output  1  registered: pixel (x,y) lies inside the bird sprite
- state  output  2  bird_state_t encoding
- score  output  16  frames survived in RUNNING, saturating

Behaviour:
- Reset (one clock with rst=1):
  - state=IDLE, pos=START_Y<<FRAC_BITS, vel=0.
  - score=0, bird_pixel=0, flap_pending=0.
  - Sync/edge flops cleared, vs_d=0.
  - Reset mid-operation overrides everything.
- Frame tick:
  - vs_d registers vs.
  - frame_tick = vs & ~vs_d, one clk_rgb cycle per frame.
  - All physics and state updates occur on the clock edge where frame_tick=1.
  - New bird_y, state and score are visible the next cycle.
- Flap input:
  - flap passes a 2-FF synchronizer, then rising-edge detect, giving flap_edge.
  - flap_edge sets flap_pending; flap_pending is cleared on every frame_tick.
  - Consumed value = flap_pending | flap_edge, so an edge coinciding with frame_tick is applied in that tick.
  - Multiple edges within one frame count as one flap.
- Arithmetic:
  - pos is unsigned, Y_WIDTH+FRAC_BITS bits.
  - vel is signed, Y_WIDTH+FRAC_BITS+1 bits; positive means downward.
  - FLOOR = (VER_ACTIVE_PIXELS-BIRD_SIZE)<<FRAC_BITS.
  - Compute the next position in a signed intermediate one bit wider; no wrap is permitted.
- IDLE:
  - pos and vel held at reset values; score held at 0.
  - On tick with a flap: vel=-FLAP_VELOCITY, pos+=vel, go to RUNNING.
- RUNNING, on each tick:
  - Velocity: flap gives vel_n=-FLAP_VELOCITY; otherwise vel_n=min(vel+GRAVITY, MAX_FALL_SPEED).
  - Position: p=pos+vel_n.
  - If p<0: pos=0, vel=0, stay RUNNING (ceiling clamp, not fatal).
  - If p>=FLOOR: pos=FLOOR, vel=0, go to DEAD.
  - Otherwise pos=p, vel=vel_n.
  - score increments (saturates at 16'hFFFF) on every tick spent in RUNNING, including the tick entering DEAD.
- DEAD:
  - pos, vel and score frozen.
  - On tick with a flap: go to IDLE with reset pos/vel, score=0.
- bird_pixel:
  - Registered, 1-cycle latency from x/y/de.
  - bird_pixel = de && BIRD_X<=x<BIRD_X+BIRD_SIZE && bird_y<=y<bird_y+BIRD_SIZE.
  - Uses the bird_y value current in that cycle.

Decomposition:
- Shared package flappy_pkg holds:
  - bird_state_t enum: IDLE=2'd0, RUNNING=2'd1, DEAD=2'd2.
  - Default physics constants (GRAVITY, FLAP_VELOCITY, MAX_FALL_SPEED, FRAC_BITS) so the renderer and the top level agree.
- One sub-module, sync_edge_detect:
  - Contains the 2-FF synchronizer and the rising-edge pulse, reset by rst.
  - Reusable for the other buttons.

Test Plan:
- Reset: rst high 1 cycle → bird_y=344, state=IDLE, score=0, bird_pixel=0.
- Idle hold: 10 vs pulses, flap low → bird_y stays 344, state IDLE, score 0.
- First flap: flap pulse (≥3 clk high), then vs rise → state RUNNING, pos=5408 (bird_y 338), score=1.
  - Next tick with no flap → vel=-90, pos=5318, bird_y=332, score=2.
- Floor death: no further flaps, ticks until bird reaches the floor → bird_y=688, state DEAD.
  - score freezes; extra ticks leave bird_y and score unchanged.
  - A flap plus tick then gives IDLE, bird_y=344, score=0.
- Ceiling clamp and coincidence:
  - Flap every frame → bird_y reaches 0, vel 0, state remains RUNNING.
  - Force an internal flap_edge in the same cycle as frame_tick → flap applied that tick (vel=-96).
- Sprite hit and reset mid-run:
  - With bird_y=344, drive de=1: x=320,y=344 → bird_pixel=1 next cycle.
  - Then x=352,y=344 → 0; x=320,y=376 → 0; de=0 → 0.
  - rst during RUNNING → IDLE/344/0 the next cycle.
